// File: rtl/clock_core_param.sv
// HH:MM:SS.cc timekeeping core with three-key set mode, blinking edit field and 8-digit 7-segment drive.
// Define CLOCK_ALARM_EN to add the alarm registers, the two alarm-set states and the alarm_o output.
module clock_core_param #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int HOUR_MODE      = 24,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLINK_TICKS    = 50
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        key_mode_i,
    input  logic        key_up_i,
    input  logic        key_down_i,
    output logic [55:0] seg_o,
    output logic        pm_o,
    output logic [2:0]  set_state_o,
`ifdef CLOCK_ALARM_EN
    output logic        alarm_o,
`endif
    output logic        tick_o
);

    localparam int DIV = CLK_HZ / 100;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(BLINK_TICKS + 1);
    localparam logic [PW-1:0] PRE_TOP   = PW'(DIV - 1);
    localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_TICKS - 1);

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_SET_HR     = 3'd1,
        ST_SET_MIN    = 3'd2,
        ST_SET_SEC    = 3'd3,
        ST_SET_AL_HR  = 3'd4,
        ST_SET_AL_MIN = 3'd5
    } state_t;

`ifdef CLOCK_ALARM_EN
    localparam state_t LAST_SET = ST_SET_AL_MIN;
`else
    localparam state_t LAST_SET = ST_SET_SEC;
`endif

    // Wrapping +1/-1 used by every editable field.
    function automatic logic [5:0] bump(input logic [5:0] v, input logic [5:0] top, input logic up);
        if (up) return (v == top) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Key synchronisers and rising-edge detect, bits are {mode, up, down}.
    logic [2:0] key_s1, key_s2, key_prev, key_edge;
    logic       mode_e, up_e, dn_e, adj_up, adj_dn;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_s1   <= '0;
            key_s2   <= '0;
            key_prev <= '0;
        end else begin
            key_s1   <= {key_mode_i, key_up_i, key_down_i};
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    assign key_edge = key_s2 & ~key_prev;
    assign {mode_e, up_e, dn_e} = key_edge;
    assign adj_up = up_e & ~dn_e & ~mode_e;
    assign adj_dn = dn_e & ~up_e & ~mode_e;

    state_t state, state_next;
    logic   in_run, to_run;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_RUN;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (mode_e) begin
            case (state)
                ST_RUN:        state_next = ST_SET_HR;
                ST_SET_HR:     state_next = ST_SET_MIN;
                ST_SET_MIN:    state_next = ST_SET_SEC;
`ifdef CLOCK_ALARM_EN
                ST_SET_SEC:    state_next = ST_SET_AL_HR;
                ST_SET_AL_HR:  state_next = ST_SET_AL_MIN;
`endif
                default:       state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        in_run      = (state == ST_RUN);
        to_run      = mode_e && (state == LAST_SET);
        set_state_o = state;
    end

    logic [PW-1:0] presc;
    logic          tick;

    assign tick   = (presc == PRE_TOP);
    assign tick_o = tick;

    // Leaving set mode restarts the centisecond phase so the clock resumes from a clean .00.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)               presc <= '0;
        else if (to_run || tick) presc <= '0;
        else                     presc <= presc + 1'b1;
    end

    logic [6:0] cs_q;
    logic [5:0] sec_q, min_q;
    logic [4:0] hr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_q  <= '0;
            sec_q <= '0;
            min_q <= '0;
            hr_q  <= '0;
        end else if (in_run) begin
            if (tick) begin
                if (cs_q == 7'd99) begin
                    cs_q <= '0;
                    if (sec_q == 6'd59) begin
                        sec_q <= '0;
                        if (min_q == 6'd59) begin
                            min_q <= '0;
                            hr_q  <= (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                        end else begin
                            min_q <= min_q + 6'd1;
                        end
                    end else begin
                        sec_q <= sec_q + 6'd1;
                    end
                end else begin
                    cs_q <= cs_q + 7'd1;
                end
            end
        end else begin
            if (to_run) cs_q <= '0;
            if (adj_up || adj_dn) begin
                case (state)
                    ST_SET_HR:  hr_q  <= 5'(bump({1'b0, hr_q}, 6'd23, adj_up));
                    ST_SET_MIN: min_q <= bump(min_q, 6'd59, adj_up);
                    ST_SET_SEC: sec_q <= bump(sec_q, 6'd59, adj_up);
                    default: ;
                endcase
            end
        end
    end

    logic [BW-1:0] blink_cnt;
    logic          blink_ph;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (in_run || (state_next != state)) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_TOP) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    logic [4:0] show_hr;
    logic [5:0] show_min;
    logic       alarm_view;

`ifdef CLOCK_ALARM_EN
    logic [4:0] al_hr_q, hr_nx;
    logic [5:0] al_min_q, min_nx;
    logic       alarm_q, alarm_hit;

    // Match the time the cascade is about to show so alarm_o rises together with hh:mm:00.00.
    always_comb begin
        min_nx    = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        hr_nx     = (min_q != 6'd59) ? hr_q : ((hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1);
        alarm_hit = in_run && tick && (cs_q == 7'd99) && (sec_q == 6'd59) &&
                    (hr_nx == al_hr_q) && (min_nx == al_min_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            al_hr_q  <= '0;
            al_min_q <= '0;
            alarm_q  <= 1'b0;
        end else begin
            if ((state == ST_SET_AL_HR) && (adj_up || adj_dn))
                al_hr_q <= 5'(bump({1'b0, al_hr_q}, 6'd23, adj_up));
            if ((state == ST_SET_AL_MIN) && (adj_up || adj_dn))
                al_min_q <= bump(al_min_q, 6'd59, adj_up);
            if (alarm_hit)
                alarm_q <= 1'b1;
            else if (in_run && !mode_e && (up_e || dn_e))
                alarm_q <= 1'b0;
        end
    end

    assign alarm_o = alarm_q;
`endif

    always_comb begin
        show_hr    = hr_q;
        show_min   = min_q;
        alarm_view = 1'b0;
`ifdef CLOCK_ALARM_EN
        if ((state == ST_SET_AL_HR) || (state == ST_SET_AL_MIN)) begin
            show_hr    = al_hr_q;
            show_min   = al_min_q;
            alarm_view = 1'b1;
        end
`endif
    end

    logic [4:0]  disp_hr;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [55:0] seg_raw;

    always_comb begin
        disp_hr = show_hr;
        pm_o    = 1'b0;
        if (HOUR_MODE == 12) begin
            pm_o = (show_hr >= 5'd12);
            if (show_hr == 5'd0)       disp_hr = 5'd12;
            else if (show_hr > 5'd12)  disp_hr = show_hr - 5'd12;
        end
    end

    assign digits = {to_bcd(7'(disp_hr)), to_bcd(7'(show_min)), to_bcd(7'(sec_q)), to_bcd(cs_q)};

    always_comb begin
        blank = '0;
        if (alarm_view) blank[3:0] = 4'hF;
        if (blink_ph) begin
            case (state)
                ST_SET_HR, ST_SET_AL_HR:   blank[7:6] = 2'b11;
                ST_SET_MIN, ST_SET_AL_MIN: blank[5:4] = 2'b11;
                ST_SET_SEC:                blank[3:2] = 2'b11;
                default: ;
            endcase
        end
    end

    always_comb begin
        seg_raw = '0;
        for (int k = 0; k < 8; k++)
            seg_raw[7*k +: 7] = blank[k] ? 7'h00 : seg7(digits[4*k +: 4]);
        seg_o = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    end

endmodule

// File: tb/tb_clock_core_param.sv
// Bench for clock_core_param: a 24h/active-low and a 12h/active-high instance share one key stream and
// are compared every cycle against a time-of-day model kept as total centiseconds since midnight.
module tb_clock_core_param;

    localparam int CLK_HZ = 1000;
    localparam int DIV    = CLK_HZ / 100;
    localparam int BLINK  = 5;
    localparam int DAY    = 8_640_000;
    localparam int HOUR   = 360_000;

    logic clk = 1'b0, rst = 1'b1;
    logic key_mode = 1'b0, key_up = 1'b0, key_down = 1'b0;
    logic [55:0] seg24, seg12;
    logic        pm24, pm12, tick24, tick12;
    logic [2:0]  st24, st12;
    logic        armed = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_core_param #(.CLK_HZ(CLK_HZ), .HOUR_MODE(24), .SEG_ACTIVE_LOW(1), .BLINK_TICKS(BLINK)) dut24 (
        .clk_i(clk), .rst_i(rst), .key_mode_i(key_mode), .key_up_i(key_up), .key_down_i(key_down),
        .seg_o(seg24), .pm_o(pm24), .set_state_o(st24), .tick_o(tick24));

    clock_core_param #(.CLK_HZ(CLK_HZ), .HOUR_MODE(12), .SEG_ACTIVE_LOW(0), .BLINK_TICKS(BLINK)) dut12 (
        .clk_i(clk), .rst_i(rst), .key_mode_i(key_mode), .key_up_i(key_up), .key_down_i(key_down),
        .seg_o(seg12), .pm_o(pm12), .set_state_o(st12), .tick_o(tick12));

    typedef struct packed {
        int         t;    // centiseconds since midnight
        int         st;   // 0 run, 1 hr, 2 min, 3 sec
        int         p;    // clocks into the current centisecond
        int         bc;   // ticks counted towards the next blink toggle
        logic       ph;
        logic [2:0] hm, hu, hd;  // key samples from the last three edges, [0] newest
    } model_t;

    model_t mdl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic model_t next_model(input model_t m, input logic km, input logic ku, input logic kd);
        model_t n;
        logic   tick, me, ue, de;
        int     h, mi, s, c, dir;
        n    = m;
        tick = (m.p == DIV - 1);
        me   = m.hm[1] & ~m.hm[2];
        ue   = m.hu[1] & ~m.hu[2];
        de   = m.hd[1] & ~m.hd[2];
        h    = m.t / HOUR;
        mi   = (m.t / 6000) % 60;
        s    = (m.t / 100) % 60;
        c    = m.t % 100;
        if (m.st == 0) begin
            if (tick) n.t = (m.t + 1) % DAY;
        end else if (!me && (ue != de)) begin
            dir = ue ? 1 : -1;
            if (m.st == 1) h  = (h + dir + 24) % 24;
            if (m.st == 2) mi = (mi + dir + 60) % 60;
            if (m.st == 3) s  = (s + dir + 60) % 60;
            n.t = h * HOUR + mi * 6000 + s * 100 + c;
        end
        n.p = (m.p + 1) % DIV;
        if (m.st != 0 && tick) begin
            if (m.bc == BLINK - 1) begin
                n.bc = 0;
                n.ph = ~m.ph;
            end else begin
                n.bc = m.bc + 1;
            end
        end
        if (me) begin
            n.st = (m.st + 1) % 4;
            n.ph = 1'b0;
            n.bc = 0;
            if (m.st == 3) begin
                n.t = n.t - n.t % 100;
                n.p = 0;
            end
        end
        n.hm = {m.hm[1:0], km};
        n.hu = {m.hu[1:0], ku};
        n.hd = {m.hd[1:0], kd};
        return n;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;  4: return 7'h66;
            5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;  8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [55:0] exp_seg(input model_t m, input bit twelve, input bit low);
        int          h, dh, mi, s, c;
        int          dig [8];
        logic [7:0]  blank;
        logic [6:0]  pat;
        logic [55:0] r;
        h  = m.t / HOUR;
        mi = (m.t / 6000) % 60;
        s  = (m.t / 100) % 60;
        c  = m.t % 100;
        dh = h;
        if (twelve) dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        dig[7] = dh / 10;  dig[6] = dh % 10;
        dig[5] = mi / 10;  dig[4] = mi % 10;
        dig[3] = s / 10;   dig[2] = s % 10;
        dig[1] = c / 10;   dig[0] = c % 10;
        blank = 8'h00;
        if (m.ph) begin
            if (m.st == 1) blank = 8'hC0;
            if (m.st == 2) blank = 8'h30;
            if (m.st == 3) blank = 8'h0C;
        end
        r = '0;
        for (int k = 0; k < 8; k++) begin
            pat = blank[k] ? 7'h00 : glyph(dig[k]);
            r[7*k +: 7] = low ? ~pat : pat;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) mdl <= '0;
        else     mdl <= next_model(mdl, key_mode, key_up, key_down);
    end

    always @(negedge clk) begin
        if (armed && !rst) begin
            check("seg24", seg24, exp_seg(mdl, 1'b0, 1'b1));
            check("seg12", seg12, exp_seg(mdl, 1'b1, 1'b0));
            check("pm24", pm24, 1'b0);
            check("pm12", pm12, (mdl.t / HOUR) >= 12);
            check("state24", st24, mdl.st);
            check("state12", st12, mdl.st);
            check("tick24", tick24, mdl.p == DIV - 1);
            check("tick12", tick12, mdl.p == DIV - 1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic press(input logic m, input logic u, input logic d, input int hold);
        @(negedge clk);
        key_mode = m;
        key_up   = u;
        key_down = d;
        repeat (hold) @(negedge clk);
        key_mode = 1'b0;
        key_up   = 1'b0;
        key_down = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [55:0] ZERO24 = {8{7'h40}};
    localparam logic [55:0] ZERO12 = {7'h06, 7'h5B, {6{7'h3F}}};

    initial begin
        int nt;
        repeat (3) @(negedge clk);
        check("rst_seg24", seg24, ZERO24);
        check("rst_seg12", seg12, ZERO12);
        check("rst_state", st24, 3'd0);
        check("rst_tick", tick24, 1'b0);
        check("rst_pm12", pm12, 1'b0);
        rst   = 1'b0;
        armed = 1'b1;

        // 1000 clocks at DIV=10 -> 100 ticks -> 00:00:01.00
        nt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tick24) nt++;
        end
        check("tick_count", nt, 100);
        check("one_sec_seg24", seg24, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h40});
        check("one_sec_seg12", seg12, {7'h06, 7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h3F, 7'h3F});

        // Preload 23:59:59 and roll over the whole day in one tick
        do_reset();
        press(1, 0, 0, 4);
        press(0, 0, 1, 4);
        press(1, 0, 0, 4);
        press(0, 0, 1, 4);
        press(1, 0, 0, 4);
        press(0, 0, 1, 4);
        press(0, 1, 0, 4);
        press(0, 0, 1, 4);
        check("preload_state", st24, 3'd3);
        press(1, 0, 0, 4);
        repeat (995) @(negedge clk);
        check("rollover_seg24", seg24, ZERO24);
        check("rollover_seg12", seg12, ZERO12);
        check("rollover_state", st24, 3'd0);

        // SET_HR: three downs, simultaneous up+down ignored, then blink
        do_reset();
        press(1, 0, 0, 4);
        repeat (3) press(0, 0, 1, 4);
        press(0, 1, 1, 4);
        check("hr21_seg24", seg24[55:42], {7'h24, 7'h79});
        check("hr21_seg12", seg12[55:42], {7'h3F, 7'h6F});
        check("hr21_pm12", pm12, 1'b1);
        repeat (20) @(negedge clk);
        check("blink_seg24", seg24[55:42], {2{7'h7F}});
        check("blink_seg12", seg12[55:42], 14'h0);
        check("blink_min24", seg24[41:28], {2{7'h40}});

        // Held key acts once, then down to 13; mode+down together only advances
        press(0, 0, 1, 20);
        repeat (7) press(0, 0, 1, 4);
        press(1, 0, 1, 4);
        repeat (2) press(0, 0, 1, 4);
        press(1, 0, 0, 4);
        press(1, 0, 0, 4);
        check("h13_state", st24, 3'd0);
        check("h13_seg12", seg12[55:42], {7'h3F, 7'h06});
        check("h13_pm12", pm12, 1'b1);
        check("min8_seg12", seg12[34:28], 7'h7F);
        check("h13_seg24", seg24[55:42], {7'h79, 7'h30});
        check("min5_seg24", seg24[41:35], 7'h12);

        // Reset while editing minutes at 37
        do_reset();
        press(1, 0, 0, 4);
        press(1, 0, 0, 4);
        repeat (37) press(0, 1, 0, 4);
        check("min37_state", st24, 3'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", st24, 3'd0);
        check("midrst_seg24", seg24, ZERO24);
        check("midrst_seg12", seg12, ZERO12);
        check("midrst_pm12", pm12, 1'b0);
        check("midrst_tick", tick24, 1'b0);
        rst = 1'b0;
        repeat (50) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
